pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM generator with one shared period counter and per-channel duty registers. Duty updates are double-buffered and take effect only at period boundaries, so outputs never glitch. The block supports edge-aligned and centre-aligned modes, an integer prescaler, full-scale 0–100 % duty, a half-period reference clock and a period-start strobe. It sits between the control logic that writes duty values and the motor and LED driver pins.

---
 rtl/pwm_multi_channel.sv | 99 +++++++++
 tb/tb_pwm_multi_channel.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_multi_channel: shared-counter PWM, double-buffered duty, edge/centre |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_3125KHz,
  input  logic                reset,
  input  logic [WIDTH:0]      duty_in,
  input  logic [SELW-1:0]     duty_sel,
  input  logic                duty_wr,
  input  logic [CHANNELS-1:0] enable,
  input  logic                center_mode,
  output logic                period_clk,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  logic             tick;
  logic [WIDTH:0]   cnt;
  logic             active_mode;
  logic [WIDTH:0]   term;
  logic [WIDTH:0]   half;
  logic             load;
  logic             wr_ok;
  logic [WIDTH-1:0] f;
  logic [WIDTH:0]   shadow      [CHANNELS];
  logic [WIDTH:0]   active_duty [CHANNELS];

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pre;
      assign tick = (pre == PW'(PRESCALE - 1));
      always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
      end
    end
  endgenerate

  // Terminal count follows the mode of the running period, not the input.
  assign term  = active_mode ? {(WIDTH+1){1'b1}} : {1'b0, {WIDTH{1'b1}}};
  assign half  = (term >> 1) + 1'b1;
  assign load  = tick && (cnt == term);
  assign wr_ok = duty_wr && (32'(duty_sel) < CHANNELS);
  assign f     = (active_mode && cnt[WIDTH]) ? ~cnt[WIDTH-1:0] : cnt[WIDTH-1:0];

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      active_mode <= 1'b0;
    end else begin
      if (tick) cnt <= load ? '0 : cnt + 1'b1;
      if (load) active_mode <= center_mode;
    end
  end

  // A write landing on the load edge bypasses the shadow straight into use.
  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i]      <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      if (wr_ok) shadow[duty_sel] <= duty_in;
      if (load) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active_duty[i] <= (wr_ok && (duty_sel == SELW'(i))) ? duty_in : shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      pwm_out      <= '0;
      period_clk   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable[i] && ({1'b0, f} < active_duty[i]);
      end
      period_clk   <= (cnt < half);
      period_start <= load;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// Bench for pwm_multi_channel: table rows and corner sequences on a PRESCALE=1
// instance, prescaler and enable behaviour on a PRESCALE=3 instance.
module tb_pwm_multi_channel;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] duty_in;
  logic [1:0] duty_sel;
  logic       duty_wr;
  logic [3:0] en0, en3;
  logic       center_mode;
  logic       pclk0, ps0, pclk3, ps3;
  logic [3:0] pwm0, pwm3;

  always #5 clk = ~clk;

  pwm_multi_channel #(.CHANNELS(4), .WIDTH(4), .PRESCALE(1)) u0 (
    .clk_3125KHz(clk), .reset(reset), .duty_in(duty_in), .duty_sel(duty_sel),
    .duty_wr(duty_wr), .enable(en0), .center_mode(center_mode),
    .period_clk(pclk0), .period_start(ps0), .pwm_out(pwm0));

  pwm_multi_channel #(.CHANNELS(4), .WIDTH(4), .PRESCALE(3)) u3 (
    .clk_3125KHz(clk), .reset(reset), .duty_in(duty_in), .duty_sel(duty_sel),
    .duty_wr(duty_wr), .enable(en3), .center_mode(center_mode),
    .period_clk(pclk3), .period_start(ps3), .pwm_out(pwm3));

  typedef struct { int ch; int duty; bit center; int high; } vec_t;
  typedef struct { int period; int high; int pclk; logic [63:0] pat; } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pat(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected high/low per counter value, straight from the compare rule.
  function automatic logic [63:0] exp_pat(input int d, input bit center);
    logic [63:0] r = '0;
    int p = center ? 32 : 16;
    for (int c = 0; c < p; c++) begin
      int fv = center ? ((c < 16) ? c : 31 - c) : c;
      if (fv < d) r[c] = 1'b1;
    end
    return r;
  endfunction

  task automatic push_exp(input int d, input bit center, input int high);
    exp_t e;
    e.period = center ? 32 : 16;
    e.high   = high;
    e.pclk   = e.period / 2;
    e.pat    = exp_pat(d, center);
    sb.push_back(e);
  endtask

  task automatic wait_start(input bit sel, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? ps3 : ps0) && n < budget);
    if (!(sel ? ps3 : ps0)) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no period_start in %0d clocks required one", budget);
    end
  endtask

  task automatic write_duty(input int ch, input int d, input bit center);
    @(negedge clk);
    duty_sel    = 2'(ch);
    duty_in     = 5'(d);
    center_mode = center;
    duty_wr     = 1'b1;
    @(posedge clk);
    #1 duty_wr = 1'b0;
  endtask

  // Called right after a period_start sample; samples one whole period of u0.
  task automatic measure(input int ch, input int wr_j, input int wr_val,
                         input int mode_j, input bit mode_val, input string tag);
    int n = 0, hi = 0, pc = 0;
    bit done = 1'b0;
    logic [63:0] pat = '0;
    exp_t e;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (pwm0[ch]) begin
        hi++;
        if (n <= 64) pat[n-1] = 1'b1;
      end
      if (pclk0) pc++;
      duty_wr = 1'b0;
      if (n == wr_j) begin
        duty_in  = 5'(wr_val);
        duty_sel = 2'(ch);
        duty_wr  = 1'b1;
      end
      if (n == mode_j) center_mode = mode_val;
      if (ps0) done = 1'b1;
    end
    duty_wr = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue required an entry", tag);
    end else begin
      e = sb.pop_front();
      check_int({tag, "_period"}, n, e.period);
      check_int({tag, "_high"}, hi, e.high);
      check_int({tag, "_pclk"}, pc, e.pclk);
      check_pat({tag, "_pattern"}, pat, e.pat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hi, pc;
    tbl[0] = '{0,  5, 1'b0,  5};
    tbl[1] = '{1,  0, 1'b0,  0};
    tbl[2] = '{1, 16, 1'b0, 16};
    tbl[3] = '{1, 31, 1'b0, 16};
    tbl[4] = '{2,  3, 1'b1,  6};
    tbl[5] = '{2, 16, 1'b1, 32};
    tbl[6] = '{3,  8, 1'b1, 16};
    tbl[7] = '{3,  1, 1'b0,  1};

    reset = 1'b0; duty_in = '0; duty_sel = '0; duty_wr = 1'b0;
    en0 = 4'hF; en3 = 4'hF; center_mode = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_int("reset_pwm0", int'(pwm0), 0);
    check_int("reset_pclk0", int'(pclk0), 0);
    check_int("reset_ps0", int'(ps0), 0);
    check_int("reset_pwm3", int'(pwm3), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_start(1'b0, 40, n);
    check_int("first_start", n, 16);

    foreach (tbl[i]) begin
      write_duty(tbl[i].ch, tbl[i].duty, tbl[i].center);
      push_exp(tbl[i].duty, tbl[i].center, tbl[i].high);
      wait_start(1'b0, 40, n);
      measure(tbl[i].ch, -1, 0, -1, 1'b0, $sformatf("row%0d", i));
    end

    // ch0 is 5: write 12 at cnt=7, then write 3 on the load edge itself.
    push_exp(5, 1'b0, 5);
    measure(0, 7, 12, -1, 1'b0, "mid_write");
    push_exp(12, 1'b0, 12);
    measure(0, 15, 3, -1, 1'b0, "load_write");
    push_exp(3, 1'b0, 3);
    measure(0, -1, 0, 5, 1'b1, "toggle_edge");
    push_exp(3, 1'b1, 6);
    measure(0, -1, 0, 10, 1'b0, "toggle_centre");
    push_exp(3, 1'b0, 3);
    measure(0, -1, 0, -1, 1'b0, "back_edge");

    // PRESCALE=3 instance, ch0 duty 3 in edge mode.
    wait_start(1'b1, 120, n);
    n = 0; hi = 0; pc = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm3[0]) hi++;
      if (pclk3) pc++;
    end while (!ps3 && n < 120);
    check_int("ps3_period", n, 48);
    check_int("ps3_pclk_high", pc, 24);
    check_int("ps3_ch0_high", hi, 9);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) check_int("ps3_pulse_width", int'(ps3), 0);
      if (j == 3) begin
        check_int("en_before_drop", int'(pwm3[0]), 1);
        en3[0] = 1'b0;
      end
      if (j == 4) begin
        check_int("en_drop", int'(pwm3[0]), 0);
        en3[0] = 1'b1;
      end
      if (j == 5) check_int("en_resume", int'(pwm3[0]), 1);
    end

    // Reset mid-period at cnt=9 with ch0 high.
    write_duty(0, 12, 1'b0);
    wait_start(1'b0, 40, n);
    wait_start(1'b0, 40, n);
    repeat (9) @(negedge clk);
    check_int("pre_reset_high", int'(pwm0[0]), 1);
    reset = 1'b1;
    #1;
    check_int("midreset_pwm0", int'(pwm0), 0);
    check_int("midreset_pclk0", int'(pclk0), 0);
    check_int("midreset_ps0", int'(ps0), 0);
    check_int("midreset_pwm3", int'(pwm3), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_start(1'b0, 40, n);
    check_int("restart_start", n, 16);
    push_exp(0, 1'b0, 0);
    measure(0, -1, 0, -1, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
